hex_cmd_ctrl: RTL

- Sequences the memory controller datapath from an ASCII character stream, typically a UART receiver.
- Parses two command forms, write `W a1 a0 d1 d0` and read `R a1 a0`.
- Converts pairs of ASCII hex digits into bytes using the same nibble mapping as the two-character hex encoder, and validates every digit.
- Issues single-cycle write/read strobes to the memory, then returns a response byte or an error code.

---
 rtl/hex_cmd_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hex_cmd_ctrl.sv
// Purpose: parse ASCII "W a1 a0 d1 d0" / "R a1 a0" commands into memory write/read strobes.
// Latency: mem_we/mem_re 1 cycle after the last char; response +1 cycle (W) or +MEM_LAT+1 cycles (R).
// Backpressure: rx_ready low in EXEC/RD_WAIT; a char offered then is dropped and flagged with err code 11.
//
// Ports: clk, reset (synchronous, active-high)
//        rx_data/rx_valid/rx_ready          character input
//        mem_addr/mem_wdata/mem_we/mem_re   memory command (registered)
//        mem_rdata                          read data, valid MEM_LAT cycles after the mem_re cycle
//        resp_valid/resp_data               response strobe and held response byte
//        err/err_code                       error strobe and held code (01 cmd, 10 hex, 11 busy drop)
// Optional feature: define HEX_CMD_LOWER_EN to accept 'a'..'f' digits and 'w'/'r' commands.
module hex_cmd_ctrl #(
  parameter int MEM_LAT = 1  // legal range 1..4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_AH, S_AL, S_DH, S_DL, S_EXEC, S_RD_WAIT
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       cmd_w;     // 1: write command, 0: read command
  logic [1:0] lat_cnt;   // remaining RD_WAIT cycles before mem_rdata is valid
  logic       acc;       // character accepted this cycle
  logic       digit_st;  // in one of the four hex-digit collection states
  logic [4:0] hex;       // {digit_ok, nibble}
  logic       is_w, is_r, is_ws;

  // Same nibble mapping as the hex encoder: '0'..'9' -> 0..9, 'A'..'F' -> 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      r = {1'b1, c[3:0] + 4'd9};
`ifdef HEX_CMD_LOWER_EN
    else if (c >= 8'h61 && c <= 8'h66)
      r = {1'b1, c[3:0] + 4'd9};
`endif
    return r;
  endfunction

  // Character classification
  always_comb begin
    hex   = hex_decode(rx_data);
    is_w  = (rx_data == 8'h57);
    is_r  = (rx_data == 8'h52);
`ifdef HEX_CMD_LOWER_EN
    is_w  = is_w | (rx_data == 8'h77);
    is_r  = is_r | (rx_data == 8'h72);
`endif
    is_ws = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (acc && (is_w || is_r)) state_nxt = S_AH;
      S_AH:      if (acc) state_nxt = hex[4] ? S_AL : S_IDLE;
      S_AL:      if (acc) state_nxt = !hex[4] ? S_IDLE : (cmd_w ? S_DH : S_EXEC);
      S_DH:      if (acc) state_nxt = hex[4] ? S_DL : S_IDLE;
      S_DL:      if (acc) state_nxt = hex[4] ? S_EXEC : S_IDLE;
      S_EXEC:    state_nxt = cmd_w ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: if (lat_cnt == 2'd0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / handshake decode from the current state
  always_comb begin
    rx_ready = (state != S_EXEC) && (state != S_RD_WAIT);
    acc      = rx_valid && rx_ready;
    digit_st = (state == S_AH) || (state == S_AL) || (state == S_DH) || (state == S_DL);
  end

  // Datapath and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_w      <= 1'b0;
      lat_cnt    <= 2'd0;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 8'h00;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      // Strobes are registered off the transition into EXEC so they line up with the EXEC cycle.
      mem_we     <= (state_nxt == S_EXEC) && cmd_w;
      mem_re     <= (state_nxt == S_EXEC) && !cmd_w;
      resp_valid <= 1'b0;
      err        <= 1'b0;

      if (rx_valid && !rx_ready) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end

      if (digit_st && acc && !hex[4]) begin
        err      <= 1'b1;
        err_code <= 2'b10;
      end

      case (state)
        S_IDLE: begin
          if (acc) begin
            if (is_w || is_r) begin
              cmd_w <= is_w;
            end else if (!is_ws) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end
          end
        end
        S_AH: if (acc && hex[4]) mem_addr[7:4]  <= hex[3:0];
        S_AL: if (acc && hex[4]) mem_addr[3:0]  <= hex[3:0];
        S_DH: if (acc && hex[4]) mem_wdata[7:4] <= hex[3:0];
        S_DL: if (acc && hex[4]) mem_wdata[3:0] <= hex[3:0];
        S_EXEC: begin
          lat_cnt <= LAT_INIT;
          if (cmd_w) begin
            resp_valid <= 1'b1;
            resp_data  <= mem_wdata;
          end
        end
        S_RD_WAIT: begin
          if (lat_cnt == 2'd0) begin
            resp_valid <= 1'b1;
            resp_data  <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
